// File: rtl/fnv_pkg.sv
// Shared constants and state encoding for the FNV-1a 32-bit hash sequencer.
package fnv_pkg;

  localparam logic [31:0] FNV_OFFSET_BASIS = 32'h811C9DC5;
  localparam logic [31:0] FNV_PRIME        = 32'h01000193;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HASH = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/fnv_1a_step.sv
// One combinational FNV-1a octet step: xor the octet in, then multiply by the prime mod 2^32.
module fnv_1a_step
  import fnv_pkg::*;
(
  input  logic [31:0] hash,
  input  logic [7:0]  octet,
  output logic [31:0] next_hash
);

  assign next_hash = (hash ^ {24'b0, octet}) * FNV_PRIME;

endmodule

// File: rtl/fnv_hash_seq.sv
// Word-to-octet sequencer for the FNV-1a 32-bit hash; one octet per cycle, partial final word.
// Optional message-length counter and msg_len port when FNV_HASH_LEN_EN is defined.
module fnv_hash_seq
  import fnv_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic [1:0]  in_bytes,
  output logic        busy,
  output logic        hash_valid,
  output logic [31:0] hash_out
`ifdef FNV_HASH_LEN_EN
  ,
  output logic [LEN_W-1:0] msg_len
`endif
);

  // Handshake: a word transfers on a rising edge where in_valid and in_ready are both high;
  // in_ready depends only on state (high in LOAD), and the source holds data until it transfers.

  state_t      state, state_next;
  logic [31:0] hash_q;
  logic [31:0] sh;
  logic [2:0]  n;
  logic        last_q;
  logic [31:0] step_out;
  logic        accept;

  fnv_1a_step u_step (
    .hash      (hash_q),
    .octet     (sh[7:0]),
    .next_hash (step_out)
  );

  assign accept   = in_valid && in_ready;
  assign hash_out = hash_q;

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    hash_valid = 1'b0;
    case (state)
      IDLE, DONE: begin
        hash_valid = (state == DONE);
        if (start) state_next = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_next = HASH;
      end
      HASH: begin
        busy = 1'b1;
        if (n == 3'd1) state_next = last_q ? DONE : LOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      hash_q <= FNV_OFFSET_BASIS;
      sh     <= '0;
      n      <= '0;
      last_q <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE, DONE: begin
          if (start) hash_q <= FNV_OFFSET_BASIS;
        end
        LOAD: begin
          if (accept) begin
            sh     <= in_data;
            last_q <= in_last;
            // in_bytes of 0 encodes a full final word
            if (in_last && (in_bytes != 2'd0)) n <= {1'b0, in_bytes};
            else                               n <= 3'd4;
          end
        end
        HASH: begin
          hash_q <= step_out;
          sh     <= sh >> 8;
          n      <= n - 3'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef FNV_HASH_LEN_EN
  // Byte count saturates instead of wrapping so an overlong message still reads as "huge".
  always_ff @(posedge clk) begin
    if (reset) begin
      msg_len <= '0;
    end else if (((state == IDLE) || (state == DONE)) && start) begin
      msg_len <= '0;
    end else if ((state == HASH) && (msg_len != {LEN_W{1'b1}})) begin
      msg_len <= msg_len + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fnv_hash_seq.sv
// Directed self-checking bench for fnv_hash_seq; msg_len checks follow FNV_HASH_LEN_EN.
module tb_fnv_hash_seq;

  localparam int          LEN_W  = 16;
  localparam logic [31:0] OFFSET = 32'h811C9DC5;
  localparam logic [31:0] H_A    = 32'hE40C292C;
  localparam logic [31:0] H_FOOB = 32'hBF9CF968;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [1:0]  in_bytes;
  logic        busy;
  logic        hash_valid;
  logic [31:0] hash_out;
`ifdef FNV_HASH_LEN_EN
  logic [LEN_W-1:0] msg_len;
`endif

  int n_checks = 0;
  int n_errors = 0;

  fnv_hash_seq #(.LEN_W(LEN_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_bytes   (in_bytes),
    .busy       (busy),
    .hash_valid (hash_valid),
`ifdef FNV_HASH_LEN_EN
    .msg_len    (msg_len),
`endif
    .hash_out   (hash_out)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_len(input string tag, input int exp);
`ifdef FNV_HASH_LEN_EN
    check(tag, 32'(msg_len), 32'(exp));
`endif
  endtask

  // reference byte-serial FNV-1a over the low nb bytes of a word
  function automatic logic [31:0] fnv_word(input logic [31:0] h, input logic [31:0] w, input int nb);
    logic [31:0] r;
    r = h;
    for (int i = 0; i < nb; i++) r = (r ^ {24'b0, w[8*i +: 8]}) * 32'h01000193;
    return r;
  endfunction

  // drivers
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // returns just after the handshake edge
  task automatic send_word(input string tag, input logic [31:0] d, input logic last, input logic [1:0] nb);
    int cnt;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_bytes = nb;
    cnt = 0;
    while (!in_ready && cnt < 20) begin
      tick();
      cnt++;
    end
    if (!in_ready) check({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_data  = 32'hX5A5A5A5 ^ 32'h0;
  endtask

  task automatic wait_done(input string tag);
    int cnt;
    cnt = 0;
    while (!hash_valid && cnt < 50) begin
      tick();
      cnt++;
    end
    check({tag, "_done"}, 32'(hash_valid), 32'd1);
  endtask

  initial begin
    int cnt;
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    in_bytes = '0;
    tick();
    tick();
    check("rst_hash", hash_out, OFFSET);
    check("rst_valid", 32'(hash_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    check_len("rst_len", 0);
    reset = 1'b0;
    tick();

    // in_valid while IDLE must not be consumed
    in_valid = 1'b1;
    in_data  = 32'h00000062;
    in_last  = 1'b1;
    in_bytes = 2'd1;
    tick();
    tick();
    in_valid = 1'b0;
    check("idle_no_consume", hash_out, OFFSET);

    // single byte "a"
    do_start();
    check("a_ready_after_start", 32'(in_ready), 32'd1);
    check("a_busy", 32'(busy), 32'd1);
    send_word("a", 32'h00000061, 1'b1, 2'd1);
    check("a_valid_low", 32'(hash_valid), 32'd0);
    tick();
    check("a_latency", 32'(hash_valid), 32'd1);
    check("a_hash", hash_out, H_A);
    check_len("a_len", 1);
    tick();
    tick();
    check("a_hold", hash_out, H_A);

    // "foobar" from DONE, with in_ready gap measurement
    do_start();
    send_word("foo1", 32'h626F6F66, 1'b0, 2'd0);
    cnt = 0;
    while (!in_ready && cnt < 20) begin
      cnt++;
      tick();
    end
    check("foo_ready_gap", 32'(cnt), 32'd4);
    send_word("foo2", 32'h00007261, 1'b1, 2'd2);
    wait_done("foo");
    check("foo_hash", hash_out, H_FOOB);
    check_len("foo_len", 6);

    // garbage in unused bytes
    do_start();
    send_word("ga", 32'hDEAD0061, 1'b1, 2'd1);
    wait_done("ga");
    check("garbage_hash", hash_out, H_A);

    // full final word via in_bytes=0, and 3-byte partial word
    do_start();
    send_word("w4", 32'h626F6F66, 1'b1, 2'd0);
    wait_done("w4");
    check("full_last_hash", hash_out, fnv_word(OFFSET, 32'h626F6F66, 4));
    check_len("full_last_len", 4);
    do_start();
    send_word("w3", 32'hFF6F6F66, 1'b1, 2'd3);
    wait_done("w3");
    check("three_byte_hash", hash_out, fnv_word(OFFSET, 32'h006F6F66, 3));
    check_len("three_byte_len", 3);

    // reset mid-HASH
    do_start();
    send_word("rm", 32'h626F6F66, 1'b0, 2'd0);
    tick();
    reset = 1'b1;
    tick();
    check("mid_rst_hash", hash_out, OFFSET);
    check("mid_rst_valid", 32'(hash_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    check_len("mid_rst_len", 0);
    reset = 1'b0;
    tick();
    do_start();
    send_word("ra", 32'h00000061, 1'b1, 2'd1);
    wait_done("ra");
    check("after_rst_hash", hash_out, H_A);

    // start pulse during HASH is ignored
    do_start();
    send_word("sb1", 32'h626F6F66, 1'b0, 2'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy_still_busy", 32'(busy), 32'd1);
    send_word("sb2", 32'h00007261, 1'b1, 2'd2);
    wait_done("sb");
    check("start_busy_hash", hash_out, H_FOOB);
    check_len("start_busy_len", 6);

    // back-to-back start from DONE
    do_start();
    check("b2b_valid_drop", 32'(hash_valid), 32'd0);
    check("b2b_hash_init", hash_out, OFFSET);
    check_len("b2b_len_clear", 0);
    send_word("b2b", 32'h00000061, 1'b1, 2'd1);
    wait_done("b2b");
    check("b2b_hash", hash_out, H_A);
    check_len("b2b_len", 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
